rf_wb_ctrl: RTL and testbench



---
 rtl/rf_pkg.sv | 14 +
 rtl/rf_wb_ctrl_if.sv | 34 +++
 rtl/rf_scoreboard.sv | 46 ++++
 rtl/rf_wb_ctrl.sv | 57 +++++
 tb/tb_rf_wb_ctrl.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared widths, writeback source encoding and request record for the register-file writeback slice
package rf_pkg;
   localparam int XLEN     = 32;
   localparam int NUM_REGS = 32;
   localparam int RADDR_W  = 5;
   typedef enum logic {
      WB_ALU = 1'b0,
      WB_LD  = 1'b1
   } wb_src_t;
   typedef struct packed {
      logic [RADDR_W-1:0] addr;
      logic [XLEN-1:0]    data;
   } wb_req_t;
endpackage

// File: rtl/rf_wb_ctrl_if.sv
// rf_wb_ctrl_if: writeback request, reservation, operand-busy and register-file write bundle
interface rf_wb_ctrl_if #(
   parameter int XLEN = 32
);
   import rf_pkg::*;
   logic               Alu_Valid;
   logic [RADDR_W-1:0] Alu_Addr;
   logic [XLEN-1:0]    Alu_Data;
   logic               Alu_Ready;
   logic               Ld_Valid;
   logic [RADDR_W-1:0] Ld_Addr;
   logic [XLEN-1:0]    Ld_Data;
   logic               Ld_Ready;
   logic               Rsv_En;
   logic [RADDR_W-1:0] Rsv_Addr;
   logic               Rsv_Stall;
   logic [RADDR_W-1:0] RAddr1_RF;
   logic [RADDR_W-1:0] RAddr2_RF;
   logic               Busy1;
   logic               Busy2;
   logic               WrEn_RF;
   logic [RADDR_W-1:0] WAddr_RF;
   logic [XLEN-1:0]    WD_RF;
   modport master (
      output Alu_Valid, Alu_Addr, Alu_Data, Ld_Valid, Ld_Addr, Ld_Data,
             Rsv_En, Rsv_Addr, RAddr1_RF, RAddr2_RF,
      input  Alu_Ready, Ld_Ready, Rsv_Stall, Busy1, Busy2, WrEn_RF, WAddr_RF, WD_RF
   );
   modport slave (
      input  Alu_Valid, Alu_Addr, Alu_Data, Ld_Valid, Ld_Addr, Ld_Data,
             Rsv_En, Rsv_Addr, RAddr1_RF, RAddr2_RF,
      output Alu_Ready, Ld_Ready, Rsv_Stall, Busy1, Busy2, WrEn_RF, WAddr_RF, WD_RF
   );
endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending-write counters with reserve/release and two busy lookups; RF_WB_BYPASS_EN releases Busy during the final write
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int CNT_W = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rsv_en,
   input  logic [RADDR_W-1:0] rsv_addr,
   input  logic               wr_en,
   input  logic [RADDR_W-1:0] wr_addr,
   input  logic [RADDR_W-1:0] raddr1,
   input  logic [RADDR_W-1:0] raddr2,
   output logic               rsv_stall,
   output logic               busy1,
   output logic               busy2
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   logic [NUM_REGS-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic rsv_ok, byp1, byp2;
   // saturated counters refuse reservations; a reserve and a release on the same register cancel out
   always_comb begin
      rsv_stall = ~rst & rsv_en & (rsv_addr != '0) & (cnt_q[rsv_addr] == CNT_MAX);
      rsv_ok    = ~rst & rsv_en & (rsv_addr != '0) & (cnt_q[rsv_addr] != CNT_MAX);
      cnt_d     = cnt_q;
      cnt_d[0]  = '0;
      for (int i = 1; i < NUM_REGS; i++)
         cnt_d[i] = (rsv_ok & (rsv_addr == RADDR_W'(i)) & ~(wr_en & (wr_addr == RADDR_W'(i)))) ? cnt_q[i] + CNT_W'(1) :
                    (wr_en & (wr_addr == RADDR_W'(i)) & ~(rsv_ok & (rsv_addr == RADDR_W'(i))) & (cnt_q[i] != '0)) ? cnt_q[i] - CNT_W'(1) :
                    cnt_q[i];
      byp1 = 1'b0;
      byp2 = 1'b0;
`ifdef RF_WB_BYPASS_EN
      byp1 = wr_en & (wr_addr == raddr1) & (cnt_q[raddr1] == CNT_W'(1));
      byp2 = wr_en & (wr_addr == raddr2) & (cnt_q[raddr2] == CNT_W'(1));
`endif
      busy1 = ~rst & (cnt_q[raddr1] != '0) & ~byp1;
      busy2 = ~rst & (cnt_q[raddr2] != '0) & ~byp2;
   end
   // counter state; x0 never accumulates
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/rf_wb_ctrl.sv
// rf_wb_ctrl: round-robin ALU/load writeback arbiter driving a registered RF write port plus pending-write scoreboard; RF_WB_BYPASS_EN masks Busy on the last outstanding write
module rf_wb_ctrl #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 2
) (
   input logic         clk,
   input logic         rst,
   rf_wb_ctrl_if.slave wb
);
   import rf_pkg::*;
   wb_src_t            last_q, last_d;
   logic               wen_q, wen_d;
   logic [RADDR_W-1:0] waddr_q, waddr_d;
   logic [XLEN-1:0]    wd_q, wd_d;
   logic               gnt_alu, gnt_ld;
   // a lone requester wins; a tie goes to the source not granted last; writes to x0 are consumed silently
   always_comb begin
      gnt_alu = ~rst & wb.Alu_Valid & (~wb.Ld_Valid | (last_q == WB_LD));
      gnt_ld  = ~rst & wb.Ld_Valid & (~wb.Alu_Valid | (last_q == WB_ALU));
      last_d  = gnt_alu ? WB_ALU : gnt_ld ? WB_LD : last_q;
      waddr_d = gnt_alu ? wb.Alu_Addr : gnt_ld ? wb.Ld_Addr : waddr_q;
      wd_d    = gnt_alu ? wb.Alu_Data : gnt_ld ? wb.Ld_Data : wd_q;
      wen_d   = (gnt_alu | gnt_ld) & (waddr_d != '0);
   end
   // pointer and output stage; reset drops any in-flight write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q  <= WB_LD;
         wen_q   <= 1'b0;
         waddr_q <= '0;
         wd_q    <= '0;
      end else begin
         last_q  <= last_d;
         wen_q   <= wen_d;
         waddr_q <= waddr_d;
         wd_q    <= wd_d;
      end
   end
   assign wb.Alu_Ready = gnt_alu;
   assign wb.Ld_Ready  = gnt_ld;
   assign wb.WrEn_RF   = wen_q;
   assign wb.WAddr_RF  = waddr_q;
   assign wb.WD_RF     = wd_q;
   rf_scoreboard #(.CNT_W(CNT_W)) u_sb (
      .clk       (clk),
      .rst       (rst),
      .rsv_en    (wb.Rsv_En),
      .rsv_addr  (wb.Rsv_Addr),
      .wr_en     (wen_q),
      .wr_addr   (waddr_q),
      .raddr1    (wb.RAddr1_RF),
      .raddr2    (wb.RAddr2_RF),
      .rsv_stall (wb.Rsv_Stall),
      .busy1     (wb.Busy1),
      .busy2     (wb.Busy2)
   );
endmodule

// File: tb/tb_rf_wb_ctrl.sv
// tb_rf_wb_ctrl: table-driven vectors with a queue of expected write-port results, plus a reset-in-flight sequence
module tb_rf_wb_ctrl;
`ifdef RF_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   typedef struct {
      logic av; logic [4:0] aa; logic [31:0] ad;
      logic lv; logic [4:0] la; logic [31:0] ld;
      logic re; logic [4:0] ra;
      logic [4:0] r1; logic [4:0] r2;
      logic ear; logic elr; logic est; logic eb1; logic eb2;
   } vec_t;
   typedef struct {
      logic g; logic wen; logic [4:0] a; logic [31:0] d;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   vec_t vecs[$];
   exp_t sb[$];
   rf_wb_ctrl_if bus ();
   rf_wb_ctrl dut (.clk(clk), .rst(rst), .wb(bus.slave));
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                               input logic lv, input logic [4:0] la, input logic [31:0] ld,
                               input logic re, input logic [4:0] ra, input logic [4:0] r1, input logic [4:0] r2,
                               input logic ear, input logic elr, input logic est, input logic eb1, input logic eb2);
      vec_t v;
      v.av = av; v.aa = aa; v.ad = ad; v.lv = lv; v.la = la; v.ld = ld;
      v.re = re; v.ra = ra; v.r1 = r1; v.r2 = r2;
      v.ear = ear; v.elr = elr; v.est = est; v.eb1 = eb1; v.eb2 = eb2;
      return v;
   endfunction
   task automatic drv(input vec_t v);
      bus.Alu_Valid = v.av; bus.Alu_Addr = v.aa; bus.Alu_Data = v.ad;
      bus.Ld_Valid = v.lv; bus.Ld_Addr = v.la; bus.Ld_Data = v.ld;
      bus.Rsv_En = v.re; bus.Rsv_Addr = v.ra;
      bus.RAddr1_RF = v.r1; bus.RAddr2_RF = v.r2;
   endtask
   task automatic stage_chk(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s queue: got empty expected an entry", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, " wren"}, bus.WrEn_RF, e.wen);
         if (e.g) begin
            chk({tag, " waddr"}, bus.WAddr_RF, e.a);
            chk({tag, " wd"}, bus.WD_RF, e.d);
         end
      end
   endtask
   initial begin
      vec_t idle;
      exp_t e;
      idle = mk(0,0,0, 0,0,0, 0,0, 0,0, 0,0,0,0,0);
      vecs.push_back(mk(1,1,32'h11, 1,2,32'h22, 0,0, 0,0, 1,0,0,0,0));
      vecs.push_back(mk(1,1,32'h11, 1,2,32'h22, 0,0, 0,0, 0,1,0,0,0));
      vecs.push_back(mk(1,1,32'h11, 1,2,32'h22, 0,0, 0,0, 1,0,0,0,0));
      vecs.push_back(mk(1,1,32'h11, 1,2,32'h22, 0,0, 0,0, 0,1,0,0,0));
      vecs.push_back(mk(1,5,32'hDEADBEEF, 0,0,0, 0,0, 0,0, 1,0,0,0,0));
      vecs.push_back(mk(0,0,0, 1,0,32'h1234, 1,0, 0,0, 0,1,0,0,0));
      vecs.push_back(mk(0,0,0, 0,0,0, 1,7, 0,0, 0,0,0,0,0));
      vecs.push_back(mk(0,0,0, 0,0,0, 1,7, 7,7, 0,0,0,1,1));
      vecs.push_back(mk(0,0,0, 0,0,0, 1,7, 7,7, 0,0,0,1,1));
      vecs.push_back(mk(0,0,0, 0,0,0, 1,7, 7,7, 0,0,1,1,1));
      vecs.push_back(mk(1,7,32'h70, 0,0,0, 0,0, 7,7, 1,0,0,1,1));
      vecs.push_back(mk(0,0,0, 1,7,32'h71, 0,0, 7,7, 0,1,0,1,1));
      vecs.push_back(mk(1,7,32'h72, 0,0,0, 1,7, 7,7, 1,0,0,1,1));
      vecs.push_back(mk(1,7,32'h73, 0,0,0, 0,0, 7,7, 1,0,0,1,1));
      vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 7,7, 0,0,0,!BYP,!BYP));
      vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 7,7, 0,0,0,0,0));
      vecs.push_back(mk(0,0,0, 0,0,0, 1,9, 9,9, 0,0,0,0,0));
      vecs.push_back(mk(1,9,32'h99, 0,0,0, 0,0, 9,9, 1,0,0,1,1));
      vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 9,9, 0,0,0,!BYP,!BYP));
      vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 9,9, 0,0,0,0,0));
      drv(mk(1,3,32'h33, 1,4,32'h44, 1,7, 7,0, 0,0,0,0,0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst alu_rdy", bus.Alu_Ready, 1'b0);
      chk("rst ld_rdy", bus.Ld_Ready, 1'b0);
      chk("rst stall", bus.Rsv_Stall, 1'b0);
      chk("rst busy1", bus.Busy1, 1'b0);
      chk("rst wren", bus.WrEn_RF, 1'b0);
      chk("rst waddr", bus.WAddr_RF, 5'd0);
      chk("rst wd", bus.WD_RF, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drv(idle);
      e.g = 1'b1; e.wen = 1'b0; e.a = 5'd0; e.d = 32'd0;
      sb.push_back(e);
      for (int i = 0; i < vecs.size(); i++) begin
         drv(vecs[i]);
         @(negedge clk);
         chk($sformatf("v%0d alu_rdy", i), bus.Alu_Ready, vecs[i].ear);
         chk($sformatf("v%0d ld_rdy", i), bus.Ld_Ready, vecs[i].elr);
         chk($sformatf("v%0d stall", i), bus.Rsv_Stall, vecs[i].est);
         chk($sformatf("v%0d busy1", i), bus.Busy1, vecs[i].eb1);
         chk($sformatf("v%0d busy2", i), bus.Busy2, vecs[i].eb2);
         stage_chk($sformatf("v%0d", i));
         e.g   = vecs[i].ear | vecs[i].elr;
         e.a   = vecs[i].ear ? vecs[i].aa : vecs[i].la;
         e.d   = vecs[i].ear ? vecs[i].ad : vecs[i].ld;
         e.wen = e.g & (e.a != 5'd0);
         sb.push_back(e);
         @(posedge clk);
         #1;
      end
      drv(mk(1,4,32'h44, 0,0,0, 1,3, 3,0, 0,0,0,0,0));
      #1;
      chk("seq alu_rdy", bus.Alu_Ready, 1'b1);
      @(posedge clk);
      #1;
      drv(mk(1,4,32'h44, 1,6,32'h66, 0,0, 3,0, 0,0,0,0,0));
      #1;
      chk("seq wren", bus.WrEn_RF, 1'b1);
      chk("seq waddr", bus.WAddr_RF, 5'd4);
      chk("seq busy1", bus.Busy1, 1'b1);
      rst = 1'b1;
      #1;
      chk("async wren", bus.WrEn_RF, 1'b0);
      chk("async waddr", bus.WAddr_RF, 5'd0);
      chk("async wd", bus.WD_RF, 32'd0);
      chk("async busy1", bus.Busy1, 1'b0);
      chk("async alu_rdy", bus.Alu_Ready, 1'b0);
      chk("async ld_rdy", bus.Ld_Ready, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("tie alu_rdy", bus.Alu_Ready, 1'b1);
      chk("tie ld_rdy", bus.Ld_Ready, 1'b0);
      chk("post busy1", bus.Busy1, 1'b0);
      @(posedge clk);
      #1;
      chk("tie wren", bus.WrEn_RF, 1'b1);
      chk("tie waddr", bus.WAddr_RF, 5'd4);
      chk("tie wd", bus.WD_RF, 32'h44);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
